maxnet_cu: RTL and testbench
============================

MAXNET_CU -- requirements
Module: maxnet_cu

Interface
REQ-001 Parameter MAX_ITER, default 15: upper bound on compute iterations before forced completion; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  begin a run; sampled only in IDLE.
REQ-005 flag  input  1  convergence indication from datapath: at most one ReLU output non-zero; combinational from the current PU results.
REQ-006 done  output  1  run complete; high for exactly one cycle.
REQ-007 address  output  2  data-memory read address; memory read is combinational.
REQ-008 ld1, ld2, ld3, ld4  output  1 each  load enables of neuron registers R1..R4.
REQ-009 mux1_sel  output  1  neuron-register input select: 0 = memory data, 1 = ReLU feedback.
REQ-010 ldm1, ldm2, ldm3, ldm4  output  1 each  load enables of the original-value output registers RO1..RO4.
REQ-011 l1, l2, l3  output  1 each  ProcessingUnit pipeline stage strobes: multiply, partial add, final sum.

Function
REQ-012 Moore FSM; every output a pure decode of state, no input-to-output combinational path.
REQ-013 States, in order: IDLE, LOAD0, LOAD1, LOAD2, LOAD3, P1, P2, P3, UPD, DONE.
REQ-014 IDLE: all outputs 0, address 0; start=1 -> LOAD0, otherwise stay.
REQ-015 LOADk (k=0..3): address=k, mux1_sel=0, ld(k+1)=1, ldm(k+1)=1, other enables 0; LOADk -> LOADk+1; LOAD3 -> P1.
REQ-016 Entry into P1 from LOAD3 clears the 4-bit iteration counter to 0.
REQ-017 P1: l1=1 only -> P2.  P2: l2=1 only -> P3.  P3: l3=1 only -> UPD.
REQ-018 UPD: mux1_sel=1, ld1..ld4=1 (ReLU results written back); iteration counter increments by 1 on exit.
REQ-019 UPD transition: flag=1 or (counter+1)==MAX_ITER -> DONE; otherwise -> P1.
REQ-020 DONE: done=1, all other enables 0, address 0 -> IDLE unconditionally.
REQ-021 flag is ignored in every state other than UPD.
REQ-022 start is ignored outside IDLE; start held high through DONE begins a new run on the cycle after returning to IDLE.
REQ-023 In every state, at most one of l1/l2/l3 is high; ldm* are high only in LOAD states.
REQ-024 Latency: start sampled high at edge E0 -> LOAD0 in cycle 1, first P1 in cycle 5, first UPD in cycle 8, done in cycle 8+4*(n-1)+1 for convergence on iteration n.

Reset
REQ-025 rst=1 at a rising edge forces IDLE and clears the iteration counter regardless of state, including mid-run.
REQ-026 After reset, all outputs are 0, address is 0, and done is 0 until a run completes.
REQ-027 rst has priority over start and flag in the same cycle.

Verification
REQ-028 rst then start pulse -> cycles 1-4: address 0,1,2,3 with ld1/ldm1..ld4/ldm4 one-hot respectively, mux1_sel=0.
REQ-029 start, flag=1 throughout -> l1 in cycle 5, l2 in cycle 6, l3 in cycle 7, ld1..ld4 and mux1_sel=1 in cycle 8, done=1 in cycle 9, IDLE in cycle 10.
REQ-030 start, flag=0 for two UPD visits then 1 -> UPD in cycles 8, 12, 16; done=1 in cycle 17.
REQ-031 flag held 0, MAX_ITER=15 -> exactly 15 UPD visits, done in cycle 8+4*14+1=65.
REQ-032 rst asserted in cycle 6 (P2) -> all outputs 0 from cycle 7; no done pulse; next start restarts at LOAD0.
REQ-033 start toggled during P1..UPD -> no effect on sequence; start=1 held continuously -> new LOAD0 two cycles after done.

Source files
------------

// File: rtl/maxnet_cu.sv
// maxnet_cu: control unit for a four-neuron MAXNET datapath.
// The FSM loads four neuron values from memory and then repeats a three-stage
// processing-unit pass followed by a ReLU write-back. It stops when the
// datapath reports convergence or when MAX_ITER passes have been made.
// Every output is decoded from the current state only.
module maxnet_cu #(
  parameter int MAX_ITER = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       flag,
  output logic       done,
  output logic [1:0] address,
  output logic       ld1,
  output logic       ld2,
  output logic       ld3,
  output logic       ld4,
  output logic       mux1_sel,
  output logic       ldm1,
  output logic       ldm2,
  output logic       ldm3,
  output logic       ldm4,
  output logic       l1,
  output logic       l2,
  output logic       l3
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD0 = 4'd1,
    S_LOAD1 = 4'd2,
    S_LOAD2 = 4'd3,
    S_LOAD3 = 4'd4,
    S_P1    = 4'd5,
    S_P2    = 4'd6,
    S_P3    = 4'd7,
    S_UPD   = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] iter_q, iter_d;
  // One bit wider than the counter so the compare against MAX_ITER never wraps.
  logic [4:0] iter_inc;

  // State and iteration counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state logic; flag is only looked at in UPD, start only in IDLE.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    iter_inc = {1'b0, iter_q} + 5'd1;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD0;
      S_LOAD0: state_d = S_LOAD1;
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: state_d = S_LOAD3;
      S_LOAD3: begin
        state_d = S_P1;
        iter_d  = 4'd0;
      end
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_UPD;
      S_UPD: begin
        iter_d = iter_inc[3:0];
        if (flag || (iter_inc == 5'(MAX_ITER))) state_d = S_DONE;
        else                                     state_d = S_P1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode of the current state.
  always_comb begin
    done     = 1'b0;
    address  = 2'd0;
    ld1      = 1'b0;
    ld2      = 1'b0;
    ld3      = 1'b0;
    ld4      = 1'b0;
    mux1_sel = 1'b0;
    ldm1     = 1'b0;
    ldm2     = 1'b0;
    ldm3     = 1'b0;
    ldm4     = 1'b0;
    l1       = 1'b0;
    l2       = 1'b0;
    l3       = 1'b0;
    case (state_q)
      S_LOAD0: begin
        address = 2'd0;
        ld1     = 1'b1;
        ldm1    = 1'b1;
      end
      S_LOAD1: begin
        address = 2'd1;
        ld2     = 1'b1;
        ldm2    = 1'b1;
      end
      S_LOAD2: begin
        address = 2'd2;
        ld3     = 1'b1;
        ldm3    = 1'b1;
      end
      S_LOAD3: begin
        address = 2'd3;
        ld4     = 1'b1;
        ldm4    = 1'b1;
      end
      S_P1: l1 = 1'b1;
      S_P2: l2 = 1'b1;
      S_P3: l3 = 1'b1;
      S_UPD: begin
        // ReLU results are written back into all four neuron registers.
        mux1_sel = 1'b1;
        ld1      = 1'b1;
        ld2      = 1'b1;
        ld3      = 1'b1;
        ld4      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maxnet_cu.sv
// Bench for maxnet_cu: expected per-cycle output vectors are derived from the
// cycle-count formulas of a run and queued when the run is launched.
module tb_maxnet_cu;

  logic       clk;
  logic       rst;
  logic       start;
  logic       flag;
  logic       done;
  logic [1:0] address;
  logic       ld1, ld2, ld3, ld4;
  logic       mux1_sel;
  logic       ldm1, ldm2, ldm3, ldm4;
  logic       l1, l2, l3;

  int nchk;
  int nerr;

  logic [14:0] exp_q[$];
  logic [14:0] act;

  maxnet_cu #(.MAX_ITER(15)) dut (
    .clk(clk), .rst(rst), .start(start), .flag(flag), .done(done),
    .address(address), .ld1(ld1), .ld2(ld2), .ld3(ld3), .ld4(ld4),
    .mux1_sel(mux1_sel), .ldm1(ldm1), .ldm2(ldm2), .ldm3(ldm3), .ldm4(ldm4),
    .l1(l1), .l2(l2), .l3(l3)
  );

  assign act = {done, address, ld4, ld3, ld2, ld1, mux1_sel,
                ldm4, ldm3, ldm2, ldm1, l1, l2, l3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Kinds: 0 IDLE, 1..4 LOAD0..3, 5 P1, 6 P2, 7 P3, 8 UPD, 9 DONE
  function automatic logic [14:0] vec_of(int k);
    logic       d_e;
    logic [1:0] a_e;
    logic [3:0] ld_e, ldm_e;
    logic       mx_e, e1, e2, e3;
    d_e = 0; a_e = 0; ld_e = 0; ldm_e = 0; mx_e = 0; e1 = 0; e2 = 0; e3 = 0;
    case (k)
      1, 2, 3, 4: begin
        a_e   = 2'(k - 1);
        ld_e  = 4'b0001 << (k - 1);
        ldm_e = 4'b0001 << (k - 1);
      end
      5: e1 = 1;
      6: e2 = 1;
      7: e3 = 1;
      8: begin mx_e = 1; ld_e = 4'hF; end
      9: d_e = 1;
      default: ;
    endcase
    return {d_e, a_e, ld_e, mx_e, ldm_e, e1, e2, e3};
  endfunction

  function automatic int done_cycle(int n);
    return 8 + 4 * (n - 1) + 1;
  endfunction

  // Expected state kind in cycle c of a run that finishes on iteration n.
  function automatic int kind_at(int c, int n);
    int dc;
    dc = done_cycle(n);
    if (c <= 0) return 0;
    if (c <= 4) return c;
    if (c < dc) return 5 + ((c - 5) % 4);
    if (c == dc) return 9;
    return 0;
  endfunction

  task automatic check(string nm, int c, logic [14:0] a, logic [14:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cycle=%0d: got %b expected %b", nm, c, a, e);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge with the DUT idle.
  task automatic do_reset();
    rst = 1; start = 0; flag = 0;
    @(negedge clk);
    check("reset_state", 0, act, 15'd0);
    rst = 0;
  endtask

  typedef struct {
    string name;
    int    conv_n;     // UPD visit on which flag is raised (or last visit)
    bit    flag_last;  // flag value presented on that visit
    int    start_mode; // 0 pulse, 1 held high, 2 random toggling
  } vec_t;

  task automatic run_vec(vec_t v);
    int dc, t, k, it;
    logic [14:0] e;
    dc = done_cycle(v.conv_n);
    t  = dc + 2;
    exp_q.delete();
    for (int c = 1; c <= t; c++) begin
      k = kind_at(c, v.conv_n);
      if (v.start_mode == 1 && c == t) k = 1;  // new run from held start
      exp_q.push_back(vec_of(k));
    end
    start = 1;
    flag  = 1'($urandom_range(0, 1));
    for (int c = 1; c <= t; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(v.name, c, act, e);
      k = kind_at(c, v.conv_n);
      case (v.start_mode)
        1:       start = 1;
        2:       start = (c < dc) ? 1'($urandom_range(0, 1)) : 1'b0;
        default: start = 0;
      endcase
      if (k == 8) begin
        it   = (c - 8) / 4 + 1;
        flag = (it == v.conv_n) ? v.flag_last : 1'b0;
      end else begin
        flag = 1'($urandom_range(0, 1));
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    nchk = 0; nerr = 0;
    rst = 1; start = 0; flag = 0;
    vecs[0] = '{"conv_iter1",   1, 1'b1, 0};
    vecs[1] = '{"conv_iter3",   3, 1'b1, 0};
    vecs[2] = '{"max_iter",    15, 1'b0, 0};
    vecs[3] = '{"conv_iter15", 15, 1'b1, 0};
    vecs[4] = '{"start_toggle", 2, 1'b1, 2};
    vecs[5] = '{"start_hold1",  1, 1'b1, 1};
    vecs[6] = '{"start_hold4",  4, 1'b1, 1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      do_reset();
    end

    // Reset mid-run in P2: outputs drop to zero, no done, clean restart.
    start = 1; flag = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("rst_mid_pre", c, act, vec_of(kind_at(c, 1)));
      start = 0;
    end
    rst = 1; flag = 1;
    for (int c = 7; c <= 10; c++) begin
      @(negedge clk);
      check("rst_mid_idle", c, act, 15'd0);
      rst = 0;
    end
    start = 1;
    @(negedge clk);
    check("rst_mid_restart0", 1, act, vec_of(1));
    start = 0;
    @(negedge clk);
    check("rst_mid_restart1", 2, act, vec_of(2));
    do_reset();

    // Reset together with start in IDLE: reset wins.
    rst = 1; start = 1;
    @(negedge clk);
    check("rst_over_start", 1, act, 15'd0);
    rst = 0; start = 0;
    @(negedge clk);
    check("rst_over_start_after", 2, act, 15'd0);

    // Reset together with flag in UPD: no done pulse follows.
    start = 1; flag = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("rst_upd_pre", c, act, vec_of(kind_at(c, 1)));
      start = 0;
    end
    rst = 1; flag = 1;
    @(negedge clk);
    check("rst_over_flag", 9, act, 15'd0);
    rst = 0; flag = 0;
    @(negedge clk);
    check("rst_over_flag_after", 10, act, 15'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
